rom_playback_sequencer: RTL and testbench
=========================================

Name: rom_playback_sequencer

Overview:
Controller that sequences the stimulus ROM and shares the lab-board control inputs between the user and the ROM. It replaces free-running counter/mux logic with a single-clock FSM. In manual mode it passes the user switch and key inputs through. In auto mode it steps the ROM address through 0..LAST_STEP, waits out the ROM latency, applies each word, and holds it for a programmable dwell. It sits between the board I/O / memoryBlock and the manual lab circuit.

Parameters:
DIVIDE_BY, 2500000, dwell length in clocks for each applied ROM word (must be >= 2).
TICK_W, 22, width of the dwell counter; must satisfy 2^TICK_W > DIVIDE_BY.
LAST_STEP, 6, final step index; the sequence is 0..LAST_STEP (must be <= 2^STEP_W-1).
STEP_W, 3, width of the step index.
ADDR_W, 8, ROM address width; upper bits are tied to 0.
ROM_LAT, 1, clocks from rom_addr change to valid rom_q (legal range 1..3).

Ports:
ADC_CLK_10  in  1  sole clock; all state changes on its rising edge.
reset_n  in  1  synchronous, active-low reset, sampled on the ADC_CLK_10 rising edge.
mode_auto  in  1  asynchronous mode select: 1 = ROM playback, 0 = manual (board SW[9]).
man_sw  in  3  manual switch inputs.
man_key1  in  1  manual key input, active-low.
rom_addr  out  ADDR_W  ROM address, equal to {zeros, step}.
rom_q  in  8  ROM data; bits [2:0] map to switches, bit [3] maps to key1; bits [7:4] are ignored.
out_sw  out  3  switch value delivered to the manual circuit.
out_key1  out  1  key1 value delivered to the manual circuit.
step_idx  out  STEP_W  current step.
auto_active  out  1  high whenever the FSM is not in IDLE; drives the HEX status.
seq_done  out  1  one-shot completion flag (see Optional Feature).

Behaviour:
- Reset (reset_n low at a clock edge):
  - state=IDLE, step=0, dwell counter=0, sync flops=0.
  - out_sw=0, out_key1=1, rom_addr=0, auto_active=0, seq_done=0.
- Synchronizer: mode_auto passes through a 2-flop synchronizer to give mode_s. No other input is synchronized; man_* are registered once.
- States:
  - IDLE: out_sw<=man_sw and out_key1<=man_key1 every cycle, so pass-through latency is 1 clock. When mode_s=1: step<=0, go to FETCH.
  - FETCH: rom_addr reflects step. Stay for exactly ROM_LAT clocks, then go to APPLY.
  - APPLY: out_sw<=rom_q[2:0], out_key1<=rom_q[3], dwell counter<=0. Lasts 1 clock, then go to HOLD.
  - HOLD: dwell counter increments each clock. On count==DIVIDE_BY-1 (the tick):
    - if step==LAST_STEP, step<=0;
    - otherwise step<=step+1;
    - then go to FETCH.
- Each step therefore occupies ROM_LAT+1+DIVIDE_BY clocks.
- Outputs change only in APPLY (auto mode) or IDLE (manual mode), so they are glitch-free to the manual circuit.
- auto_active is registered: 1 in FETCH, APPLY, HOLD, DONE; 0 in IDLE.
- Leaving auto mode: mode_s=0 takes priority over every other transition in every state. Next state is IDLE, step<=0, dwell counter<=0, and pass-through resumes on the following edge.
- Reset mid-sequence: identical to power-on reset; no partial step is retained.
- Mode toggled back to 1 while in IDLE: the sequence restarts from step 0.

Optional Feature:
SEQ_ONESHOT_EN.
- Defined: at the tick in HOLD with step==LAST_STEP, go to state DONE instead of wrapping.
  - DONE holds the outputs and step, and sets seq_done=1 (auto_active stays 1).
  - DONE exits only via mode_s=0, which goes to IDLE and clears seq_done.
- Undefined: the sequence loops continuously; state DONE is not built and seq_done is tied to 0.

Test Plan:
1. Reset and pass-through: DIVIDE_BY=4, ROM_LAT=1. Hold reset_n=0 for 3 clocks with man_sw=3'b101, man_key1=0. During reset out_sw=0, out_key1=1. One clock after release, out_sw=101 and out_key1=0; auto_active=0.
2. Auto entry and sequence: ROM word k = {4'h0, k[0], k[2:0]}. Raise mode_auto. auto_active=1 three edges later and rom_addr=0. out_sw=0 appears after ROM_LAT+1 clocks. rom_addr then steps 0,1,2,3,4,5,6,0 every 6 clocks, and out_sw/out_key1 follow the table.
3. Wrap boundary: at step 6 the tick gives rom_addr=0 and step_idx=0, never 7.
4. Exit mid-HOLD: drop mode_auto at step 3. Within 3 clocks state=IDLE, step_idx=0, out_sw=man_sw, and man_key1 passes through; no further rom_addr change.
5. Synchronous reset during FETCH: reset_n=0 for one edge. All outputs return to reset values on that edge; with mode_auto still 1, the sequence restarts at step 0.
6. SEQ_ONESHOT_EN defined: after step 6 the dwell completes, seq_done=1, and out_sw holds word 6 indefinitely. Dropping mode_auto clears seq_done and restores pass-through.

Source files
------------

// File: rtl/rom_playback_sequencer.sv
// rom_playback_sequencer: steps a stimulus ROM onto the lab-board switch/key lines, or passes the user inputs through in manual mode.
// Optional build macro SEQ_ONESHOT_EN: stop in DONE after the last step instead of looping.
module rom_playback_sequencer #(
  parameter int DIVIDE_BY = 2500000,
  parameter int TICK_W    = 22,
  parameter int LAST_STEP = 6,
  parameter int STEP_W    = 3,
  parameter int ADDR_W    = 8,
  parameter int ROM_LAT   = 1
) (
  input  logic              ADC_CLK_10,
  input  logic              reset_n,
  input  logic              mode_auto,
  input  logic [2:0]        man_sw,
  input  logic              man_key1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  output logic [2:0]        out_sw,
  output logic              out_key1,
  output logic [STEP_W-1:0] step_idx,
  output logic              auto_active,
  output logic              seq_done
);
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    APPLY,
`ifdef SEQ_ONESHOT_EN
    HOLD,
    DONE
`else
    HOLD
`endif
  } state_t;

  state_t            state;
  logic [STEP_W-1:0] step;
  logic [TICK_W-1:0] cnt;
  logic              mode_m, mode_s;
  logic              unused_rom_hi;

  assign rom_addr      = ADDR_W'(step);
  assign step_idx      = step;
  assign unused_rom_hi = ^rom_q[7:4];

`ifndef SEQ_ONESHOT_EN
  assign seq_done = 1'b0;
`endif

  // Mode synchronizer plus the sequencing FSM; cnt times both ROM latency in FETCH and dwell in HOLD.
  always_ff @(posedge ADC_CLK_10) begin
    if (!reset_n) begin
      state       <= IDLE;
      step        <= '0;
      cnt         <= '0;
      mode_m      <= 1'b0;
      mode_s      <= 1'b0;
      out_sw      <= 3'b000;
      out_key1    <= 1'b1;
      auto_active <= 1'b0;
`ifdef SEQ_ONESHOT_EN
      seq_done    <= 1'b0;
`endif
    end else begin
      mode_m <= mode_auto;
      mode_s <= mode_m;
      if (state == IDLE) begin
        out_sw   <= man_sw;
        out_key1 <= man_key1;
      end
      if (!mode_s) begin
        state       <= IDLE;
        step        <= '0;
        cnt         <= '0;
        auto_active <= 1'b0;
`ifdef SEQ_ONESHOT_EN
        seq_done    <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            step        <= '0;
            cnt         <= '0;
            state       <= FETCH;
            auto_active <= 1'b1;
          end
          FETCH: begin
            if (cnt == TICK_W'(ROM_LAT - 1)) begin
              cnt   <= '0;
              state <= APPLY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          APPLY: begin
            out_sw   <= rom_q[2:0];
            out_key1 <= rom_q[3];
            cnt      <= '0;
            state    <= HOLD;
          end
          HOLD: begin
            if (cnt == TICK_W'(DIVIDE_BY - 1)) begin
              cnt <= '0;
              if (step == STEP_W'(LAST_STEP)) begin
`ifdef SEQ_ONESHOT_EN
                state    <= DONE;
                seq_done <= 1'b1;
`else
                step  <= '0;
                state <= FETCH;
`endif
              end else begin
                step  <= step + 1'b1;
                state <= FETCH;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef SEQ_ONESHOT_EN
          DONE: state <= DONE;
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rom_playback_sequencer.sv
// tb_rom_playback_sequencer: directed checks of pass-through, ROM playback timing, wrap, exit and reset.
module tb_rom_playback_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode_auto = 1'b0;
  logic [2:0] man_sw = 3'b000;
  logic       man_key1 = 1'b1;
  logic [7:0] rom_addr;
  logic [7:0] rom_q = 8'h00;
  logic [2:0] out_sw;
  logic       out_key1;
  logic [2:0] step_idx;
  logic       auto_active;
  logic       seq_done;
  int         n_tests = 0;
  int         n_fail = 0;

  rom_playback_sequencer #(
    .DIVIDE_BY(4), .TICK_W(4), .LAST_STEP(6), .STEP_W(3), .ADDR_W(8), .ROM_LAT(1)
  ) dut (
    .ADC_CLK_10(clk), .reset_n(reset_n), .mode_auto(mode_auto), .man_sw(man_sw),
    .man_key1(man_key1), .rom_addr(rom_addr), .rom_q(rom_q), .out_sw(out_sw),
    .out_key1(out_key1), .step_idx(step_idx), .auto_active(auto_active), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] word(input int k);
    logic [2:0] b;
    b = k[2:0];
    return {4'h0, b[0], b};
  endfunction

  always @(posedge clk) rom_q <= word(int'(rom_addr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] w;
    man_sw = 3'b101; man_key1 = 1'b0;
    tick(3);
    check("rst_sw", out_sw, 0);
    check("rst_key1", out_key1, 1);
    check("rst_active", auto_active, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_step", step_idx, 0);
    check("rst_done", seq_done, 0);
    reset_n = 1'b1;
    tick();
    check("pass_sw", out_sw, 5);
    check("pass_key1", out_key1, 0);
    check("pass_active", auto_active, 0);
    man_sw = 3'b010; man_key1 = 1'b1;
    tick();
    check("pass2_sw", out_sw, 2);
    check("pass2_key1", out_key1, 1);

    mode_auto = 1'b1;
    tick(2);
    check("sync_active_lo", auto_active, 0);
    tick();
    check("entry_active", auto_active, 1);
    check("entry_addr", rom_addr, 0);
    check("entry_sw_held", out_sw, 2);
    tick();
    check("fetch_sw_held", out_sw, 2);
    tick();
    check("apply0_sw", out_sw, 0);
    check("apply0_key1", out_key1, 0);
    for (int k = 1; k <= 10; k++) begin
      tick(3);
      check("dwell_step", step_idx, (k - 1) % 7);
      tick();
      check("step_idx", step_idx, k % 7);
      check("step_addr", rom_addr, k % 7);
      tick();
      check("fetch_sw", out_sw, word((k - 1) % 7) & 8'h07);
      tick();
      w = word(k % 7);
      check("apply_sw", out_sw, w[2:0]);
      check("apply_key1", out_key1, w[3]);
    end

    mode_auto = 1'b0; man_sw = 3'b110; man_key1 = 1'b0;
    tick(3);
    check("exit_active", auto_active, 0);
    check("exit_step", step_idx, 0);
    check("exit_addr", rom_addr, 0);
    check("exit_sw_held", out_sw, 3);
    tick();
    check("exit_pass_sw", out_sw, 6);
    check("exit_pass_key1", out_key1, 0);
    man_key1 = 1'b1;
    tick();
    check("exit_key1", out_key1, 1);
    tick(8);
    check("idle_addr", rom_addr, 0);
    check("idle_active", auto_active, 0);

    mode_auto = 1'b1;
    tick(3);
    check("re_active", auto_active, 1);
    tick(6);
    check("re_step1", step_idx, 1);
    check("re_key1_w0", out_key1, 0);
    reset_n = 1'b0;
    tick();
    check("mrst_key1", out_key1, 1);
    check("mrst_sw", out_sw, 0);
    check("mrst_step", step_idx, 0);
    check("mrst_addr", rom_addr, 0);
    check("mrst_active", auto_active, 0);
    reset_n = 1'b1;
    tick();
    check("mrst_pass_sw", out_sw, 6);
    tick(2);
    check("mrst_restart", auto_active, 1);
    check("mrst_restart_addr", rom_addr, 0);
    tick(2);
    check("mrst_apply_sw", out_sw, 0);
    check("mrst_apply_key1", out_key1, 0);

    tick(39);
    check("last_step", step_idx, 6);
    check("last_done_lo", seq_done, 0);
    tick();
`ifdef SEQ_ONESHOT_EN
    check("done_flag", seq_done, 1);
    check("done_step", step_idx, 6);
    check("done_sw", out_sw, 6);
    tick(20);
    check("done_hold_flag", seq_done, 1);
    check("done_hold_sw", out_sw, 6);
    check("done_hold_key1", out_key1, 0);
    check("done_active", auto_active, 1);
    mode_auto = 1'b0; man_sw = 3'b001; man_key1 = 1'b1;
    tick(3);
    check("done_clear", seq_done, 0);
    tick();
    check("done_pass_sw", out_sw, 1);
    check("done_pass_key1", out_key1, 1);
`else
    check("wrap_step", step_idx, 0);
    check("wrap_done", seq_done, 0);
    tick(2);
    check("wrap_sw", out_sw, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
